// File: rtl/lcd_bus_sched_pkg.sv
// Shared types and HD44780 constants for the character LCD bus scheduler.
package lcd_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    IDLE,
    SETUP,
    PULSE,
    EXEC
  } state_t;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] HOME          = 8'h02;
  localparam logic [7:0] ENTRY_INC     = 8'h06;

  localparam int INIT_LEN = 6;
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  // Entry 0 is sent first; the 8-bit function set is repeated three times.
  localparam logic [INIT_LEN-1:0][7:0] INIT_TABLE = {
    ENTRY_INC, CLEAR, DISP_ON, FUNC_SET_8B2L, FUNC_SET_8B2L, FUNC_SET_8B2L
  };

  // Clear and home need the long execution wait, but only as commands.
  function automatic logic is_long_cmd(input logic rs_bit, input logic [7:0] byte_val);
    return !rs_bit && (byte_val == CLEAR || byte_val == HOME);
  endfunction

endpackage

// File: rtl/lcd_bus_sched_if.sv
// Requester-side handshake bundle: two byte writers sharing the LCD.
interface lcd_bus_sched_if;
  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] rs;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [1:0] ack;
  logic       ready;

  modport master (
    output req, lock, rs, data0, data1,
    input  ack, ready
  );

  modport slave (
    input  req, lock, rs, data0, data1,
    output ack, ready
  );
endinterface

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin arbiter; a locked last owner keeps exclusive access.
module lcd_rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic       done,
  input  logic       ptr,
  input  logic       last,
  input  logic       last_valid,
  output logic       grant,
  output logic       valid,
  output logic       ptr_next
);

  logic owner_hold;

  assign owner_hold = last_valid && lock[last];

  // While an owner holds its lock the other side waits, even if the owner is quiet.
  always_comb begin
    grant = ptr;
    valid = 1'b0;
    if (owner_hold) begin
      grant = last;
      valid = req[last];
    end else if (req == 2'b11) begin
      grant = ptr;
      valid = 1'b1;
    end else if (req[0]) begin
      grant = 1'b0;
      valid = 1'b1;
    end else if (req[1]) begin
      grant = 1'b1;
      valid = 1'b1;
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (done && !lock[last]) begin
      ptr_next = ~last;
    end
  end

endmodule

// File: rtl/lcd_bus_sched.sv
// HD44780 bus sequencer: runs power-up init, then shares the bus between two requesters.
module lcd_bus_sched
  import lcd_pkg::*;
#(
  parameter int E_HIGH     = 25,
  parameter int WAIT_SHORT = 2000,
  parameter int WAIT_LONG  = 82000,
  parameter int INIT_WAIT  = 750000
) (
  input  logic             clk,
  input  logic             reset,
  lcd_bus_sched_if.slave   bus,
  output logic             LCD_RS,
  output logic             LCD_E,
  output logic [7:0]       LCD_D
);

  localparam int CNT_MAX = (INIT_WAIT > WAIT_LONG) ? INIT_WAIT : WAIT_LONG;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          init_active, init_active_n;
  logic [2:0]    init_idx, init_idx_n;
  logic          cur_idx, cur_idx_n;
  logic          last_valid, last_valid_n;
  logic          ptr, ptr_n;
  logic          e_n, rs_n;
  logic [7:0]    d_n;
  logic [1:0]    ack_q, ack_n;
  logic          ready_q, ready_n;

  logic          grant, grant_valid, done, ptr_next;

  lcd_rr_arb2 u_arb (
    .req        (bus.req),
    .lock       (bus.lock),
    .done       (done),
    .ptr        (ptr),
    .last       (cur_idx),
    .last_valid (last_valid),
    .grant      (grant),
    .valid      (grant_valid),
    .ptr_next   (ptr_next)
  );

  assign bus.ack   = ack_q;
  assign bus.ready = ready_q;

  // Every register's next value is computed here so all pins stay registered.
  always_comb begin
    state_n       = state;
    cnt_n         = (cnt != '0) ? cnt - CW'(1) : cnt;
    init_active_n = init_active;
    init_idx_n    = init_idx;
    cur_idx_n     = cur_idx;
    last_valid_n  = last_valid;
    ptr_n         = ptr;
    e_n           = 1'b0;
    rs_n          = LCD_RS;
    d_n           = LCD_D;
    ack_n         = 2'b00;
    ready_n       = ready_q;
    done          = 1'b0;

    case (state)
      POWERUP: begin
        if (cnt == '0) begin
          state_n       = SETUP;
          cnt_n         = '0;
          init_active_n = 1'b1;
          init_idx_n    = 3'd0;
          rs_n          = 1'b0;
          d_n           = INIT_TABLE[0];
        end
      end
      IDLE: begin
        if (grant_valid) begin
          state_n   = SETUP;
          cnt_n     = '0;
          cur_idx_n = grant;
          rs_n      = bus.rs[grant];
          d_n       = grant ? bus.data1 : bus.data0;
        end
      end
      SETUP: begin
        state_n = PULSE;
        cnt_n   = CW'(E_HIGH - 1);
        e_n     = 1'b1;
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = EXEC;
          cnt_n   = is_long_cmd(LCD_RS, LCD_D) ? CW'(WAIT_LONG - 1) : CW'(WAIT_SHORT - 1);
        end else begin
          e_n = 1'b1;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          if (init_active && init_idx != INIT_LAST) begin
            state_n    = SETUP;
            cnt_n      = '0;
            init_idx_n = init_idx + 3'd1;
            rs_n       = 1'b0;
            d_n        = INIT_TABLE[init_idx + 3'd1];
          end else if (init_active) begin
            state_n       = IDLE;
            cnt_n         = '0;
            init_active_n = 1'b0;
            ready_n       = 1'b1;
          end else begin
            state_n        = IDLE;
            cnt_n          = '0;
            ack_n[cur_idx] = 1'b1;
            done           = 1'b1;
            last_valid_n   = 1'b1;
            ptr_n          = ptr_next;
          end
        end
      end
      default: begin
        state_n = POWERUP;
        cnt_n   = CW'(INIT_WAIT - 1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= POWERUP;
      cnt         <= CW'(INIT_WAIT - 1);
      init_active <= 1'b0;
      init_idx    <= 3'd0;
      cur_idx     <= 1'b0;
      last_valid  <= 1'b0;
      ptr         <= 1'b0;
      LCD_E       <= 1'b0;
      LCD_RS      <= 1'b0;
      LCD_D       <= 8'h00;
      ack_q       <= 2'b00;
      ready_q     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      init_active <= init_active_n;
      init_idx    <= init_idx_n;
      cur_idx     <= cur_idx_n;
      last_valid  <= last_valid_n;
      ptr         <= ptr_n;
      LCD_E       <= e_n;
      LCD_RS      <= rs_n;
      LCD_D       <= d_n;
      ack_q       <= ack_n;
      ready_q     <= ready_n;
    end
  end

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Directed bench for lcd_bus_sched with shortened timing (E_HIGH=2, waits 4/8, power-up 10).
module tb_lcd_bus_sched;

  logic       clk;
  logic       reset;
  logic       lcd_rs;
  logic       lcd_e;
  logic [7:0] lcd_d;

  int compared   = 0;
  int mismatched = 0;

  lcd_bus_sched_if bus ();

  lcd_bus_sched #(
    .E_HIGH     (2),
    .WAIT_SHORT (4),
    .WAIT_LONG  (8),
    .INIT_WAIT  (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .LCD_RS (lcd_rs),
    .LCD_E  (lcd_e),
    .LCD_D  (lcd_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req_v, input logic [1:0] lock_v,
                               input logic [1:0] rs_v, input logic [7:0] d0, input logic [7:0] d1);
    bus.req   = req_v;
    bus.lock  = lock_v;
    bus.rs    = rs_v;
    bus.data0 = d0;
    bus.data1 = d1;
  endtask

  // Reset is raised mid-cycle; the bench resumes mid-cycle in POWERUP cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Expected {ready, ack, E, RS, D} per cycle from POWERUP cycle 0 to the first IDLE.
  task automatic check_init(input string name);
    logic [7:0]  tbl [6];
    logic [12:0] exp_q [$];
    int w;
    tbl = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, 2'b00, 1'b0, 1'b0, 8'h00});
    for (int b = 0; b < 6; b++) begin
      w = (tbl[b] == 8'h01) ? 8 : 4;
      exp_q.push_back({1'b0, 2'b00, 1'b0, 1'b0, tbl[b]});
      for (int p = 0; p < 2; p++) exp_q.push_back({1'b0, 2'b00, 1'b1, 1'b0, tbl[b]});
      for (int x = 0; x < w; x++) exp_q.push_back({1'b0, 2'b00, 1'b0, 1'b0, tbl[b]});
    end
    exp_q.push_back({1'b1, 2'b00, 1'b0, 1'b0, 8'h06});
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checkOutput($sformatf("%s c%0d", name, i),
                  32'({bus.ready, bus.ack, lcd_e, lcd_rs, lcd_d}), 32'(exp_q[i]));
    end
  endtask

  // Called mid IDLE cycle t with a request already presented; ends mid ack cycle.
  task automatic expect_service(input string name, input int who, input logic rs_v,
                                input logic [7:0] d, input int w);
    logic [1:0] oh;
    logic [1:0] exp_ack;
    logic       exp_e;
    oh = (who == 1) ? 2'b10 : 2'b01;
    for (int k = 1; k <= 4 + w; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (who == 1) bus.data1 = ~bus.data1;
        else          bus.data0 = ~bus.data0;
      end
      exp_e   = (k == 2 || k == 3);
      exp_ack = (k == 4 + w) ? oh : 2'b00;
      checkOutput($sformatf("%s k%0d", name, k),
                  32'({bus.ack, lcd_e, lcd_rs, lcd_d}), 32'({exp_ack, exp_e, rs_v, d}));
    end
  endtask

  task automatic serve_one(input string name, input int who, input logic rs_v,
                           input logic [7:0] d, input int w);
    if (who == 1) applyStimulus(2'b10, 2'b00, {rs_v, 1'b0}, 8'h00, d);
    else          applyStimulus(2'b01, 2'b00, {1'b0, rs_v}, d, 8'h00);
    expect_service(name, who, rs_v, d, w);
    applyStimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    do_reset();
    check_init("init");

    serve_one("data41", 0, 1'b1, 8'h41, 4);
    serve_one("clear", 0, 1'b0, 8'h01, 8);
    serve_one("req1", 1, 1'b1, 8'h42, 4);

    for (int n = 0; n < 4; n++) begin
      applyStimulus(2'b11, 2'b00, 2'b11, 8'(8'h60 + n), 8'(8'h70 + n));
      expect_service($sformatf("alt%0d", n), n % 2, 1'b1,
                     (n % 2 == 1) ? 8'(8'h70 + n) : 8'(8'h60 + n), 4);
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);

    applyStimulus(2'b11, 2'b10, 2'b01, 8'h55, 8'h80);
    expect_service("lock80", 1, 1'b0, 8'h80, 4);
    applyStimulus(2'b11, 2'b10, 2'b11, 8'h55, 8'h41);
    expect_service("lockA", 1, 1'b1, 8'h41, 4);
    applyStimulus(2'b11, 2'b10, 2'b11, 8'h55, 8'h42);
    expect_service("lockB", 1, 1'b1, 8'h42, 4);
    applyStimulus(2'b01, 2'b10, 2'b11, 8'h55, 8'h42);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("lockhold c%0d", c), 32'({bus.ack, lcd_e, lcd_d}), 32'({2'b00, 1'b0, 8'h42}));
    end
    applyStimulus(2'b01, 2'b00, 2'b11, 8'h55, 8'h42);
    expect_service("after_lock", 0, 1'b1, 8'h55, 4);
    applyStimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);

    applyStimulus(2'b01, 2'b00, 2'b01, 8'h41, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pulse_before_reset", 32'(lcd_e), 32'(1));
    do_reset();
    checkOutput("after_reset", 32'({lcd_e, bus.ready, bus.ack}), 32'(0));
    check_init("reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
